act_seq_ctrl: RTL and testbench

- Sequencer for the 8-lane int8 neuron activation unit that sits after the bias-add stage of the systolic array.
- Latches a per-layer activation function code and row count on start, then streams bias-added 64-bit row words into the activation unit through a valid/ready handshake.
- Drives the activation unit's enable and func inputs, and returns activated rows downstream with backpressure.
- Signals completion of the layer with a one-cycle done pulse.

---
 rtl/act_seq_ctrl_pkg.sv | 22 ++
 rtl/act_seq_ctrl_out_slot.sv | 46 ++++
 rtl/act_seq_ctrl.sv | 114 +++++++++++
 tb/tb_act_seq_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/act_seq_ctrl_pkg.sv
// Shared types and constants for the activation-unit sequencer.
// Activation codes, controller states and lane geometry of the 8-lane int8 unit.
package act_pkg;

    localparam int ACT_LANES  = 8;
    localparam int ACT_LANE_W = 8;

    typedef enum logic [1:0] {
        ACT_RELU     = 2'd0,
        ACT_BINARY   = 2'd1,
        ACT_IDENTITY = 2'd2,
        ACT_LEAKY    = 2'd3
    } act_func_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } act_state_t;

endpackage

// File: rtl/act_seq_ctrl_out_slot.sv
// One-entry output slot: tracks whether the activation unit holds an unconsumed row
// and whether that row is the last one of the layer.
module act_out_slot (
    input  logic clk,
    input  logic n_rst,
    input  logic load,
    input  logic load_last,
    input  logic out_ready,
    output logic out_valid,
    output logic out_last,
    output logic slot_free
);

    logic valid_q, valid_d;
    logic last_q,  last_d;
    logic pop;

    assign pop       = valid_q && out_ready;
    assign slot_free = !valid_q || out_ready;
    assign out_valid = valid_q;
    assign out_last  = last_q;

    // A load in the same cycle as a pop wins, keeping the slot full at full throughput.
    always_comb begin
        valid_d = valid_q;
        last_d  = last_q;
        if (load) begin
            valid_d = 1'b1;
            last_d  = load_last;
        end else if (pop) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: rtl/act_seq_ctrl.sv
// Layer sequencer for the activation unit: latches func/rows on start, streams bias rows
// into the unit and returns activated rows downstream; one-cycle done at layer end.
module act_seq_ctrl
    import act_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    input  logic [1:0]        cfg_func,
    input  logic [CNT_W-1:0]  cfg_rows,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              act_enable,
    output logic [1:0]        act_func,
    output logic [DATA_W-1:0] act_bias,
    input  logic [DATA_W-1:0] act_out,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    act_state_t       state_q, state_d;
    act_func_t        func_q, func_d;
    logic [CNT_W-1:0] counter_q, counter_d;
    logic [CNT_W-1:0] rows_q, rows_d;
    logic             slot_free;
    logic             last_pending;

    assign act_bias   = in_data;
    assign act_func   = func_q;
    assign out_data   = act_out;
    assign act_enable = in_ready && in_valid;

    // rows_q is never zero in RUN, so rows_q-1 cannot underflow while it matters.
    assign last_pending = act_enable && (counter_q == rows_q - CNT_W'(1));

    always_comb begin
        state_d   = state_q;
        func_d    = func_q;
        counter_d = counter_q;
        rows_d    = rows_q;
        in_ready  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (cfg_rows != '0) begin
                        state_d   = RUN;
                        func_d    = act_func_t'(cfg_func);
                        rows_d    = cfg_rows;
                        counter_d = '0;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            RUN: begin
                busy     = 1'b1;
                in_ready = slot_free;
                if (act_enable) begin
                    counter_d = counter_q + CNT_W'(1);
                    if (last_pending) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (out_valid && out_ready && out_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= IDLE;
            func_q    <= ACT_RELU;
            counter_q <= '0;
            rows_q    <= '0;
        end else begin
            state_q   <= state_d;
            func_q    <= func_d;
            counter_q <= counter_d;
            rows_q    <= rows_d;
        end
    end

    act_out_slot u_out_slot (
        .clk       (clk),
        .n_rst     (n_rst),
        .load      (act_enable),
        .load_last (last_pending),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_last  (out_last),
        .slot_free (slot_free)
    );

endmodule

// File: tb/tb_act_seq_ctrl.sv
// Randomized bench for act_seq_ctrl with a transaction-level reference model and a
// behavioural stand-in for the activation unit.
module tb_act_seq_ctrl;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        start;
    logic [1:0]  cfg_func;
    logic [7:0]  cfg_rows;
    logic        in_valid;
    logic [63:0] in_data;
    logic        in_ready;
    logic        act_enable;
    logic [1:0]  act_func;
    logic [63:0] act_bias;
    logic [63:0] act_out;
    logic        out_valid;
    logic [63:0] out_data;
    logic        out_last;
    logic        out_ready;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    act_seq_ctrl #(.DATA_W(64), .CNT_W(8)) dut (
        .clk(clk), .n_rst(n_rst), .start(start), .cfg_func(cfg_func), .cfg_rows(cfg_rows),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .act_enable(act_enable), .act_func(act_func), .act_bias(act_bias), .act_out(act_out),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
        .busy(busy), .done(done)
    );

    function automatic logic [63:0] act_f(input logic [63:0] x, input logic [1:0] f);
        logic [63:0]       r;
        logic signed [7:0] l;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            l = x[i*8 +: 8];
            case (f)
                2'd0:    r[i*8 +: 8] = (l < 0) ? 8'd0 : l;
                2'd1:    r[i*8 +: 8] = (l > 0) ? 8'd1 : 8'd0;
                2'd2:    r[i*8 +: 8] = l;
                default: r[i*8 +: 8] = (l < 0) ? (l >>> 3) : l;
            endcase
        end
        return r;
    endfunction

    // Activation unit stand-in: registered, updates only when enabled.
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) act_out <= '0;
        else if (act_enable) act_out <= act_f(act_bias, act_func);
    end

    int n_err = 0;
    int n_checks = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a layer is a count of rows still to accept plus a one-deep output queue.
    bit          m_active;
    int          m_left;
    logic [1:0]  m_func;
    bit          m_full;
    logic [63:0] m_data;
    bit          m_last;
    bit          m_done;
    bit          last_acc;
    logic [63:0] pops[$];
    logic [63:0] dir_q[$];

    task automatic model_reset();
        m_active = 0; m_left = 0; m_func = 2'd0;
        m_full = 0; m_data = '0; m_last = 0; m_done = 0;
    endtask

    task automatic tick();
        bit exp_ir, idle, acc;
        #1;
        exp_ir = m_active && (m_left > 0) && (!m_full || out_ready);
        chk("busy",       busy,       m_active);
        chk("in_ready",   in_ready,   exp_ir);
        chk("act_enable", act_enable, exp_ir && in_valid);
        chk("out_valid",  out_valid,  m_full);
        chk("out_last",   out_last,   m_full && m_last);
        chk("done",       done,       m_done);
        chk("act_func",   act_func,   m_func);
        chk("act_bias",   act_bias,   in_data);
        if (m_full) chk("out_data", out_data, m_data);

        idle = !m_active && !m_done;
        acc  = exp_ir && in_valid;
        m_done = 0;
        if (m_full && out_ready) begin
            pops.push_back(out_data);
            m_full = 0;
            if (m_last) begin
                m_active = 0;
                m_done = 1;
            end
        end
        if (acc) begin
            m_full = 1;
            m_data = act_f(in_data, m_func);
            m_last = (m_left == 1);
            m_left--;
        end
        if (idle && start && n_rst) begin
            if (cfg_rows == 8'd0) begin
                m_done = 1;
            end else begin
                m_active = 1;
                m_left   = cfg_rows;
                m_func   = cfg_func;
            end
        end
        last_acc = acc;
        @(negedge clk);
    endtask

    task automatic do_layer(input logic [1:0] func, input int rows, input int vpct,
                            input int rpct, input bit stall, input bit chaos);
        int  stall_cnt = 0;
        bit  stalled = 0;
        bit  held = 0;
        int  cyc = 0;
        start = 1'b1; cfg_func = func; cfg_rows = 8'(rows);
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        start = 1'b0;
        while ((m_active || m_done) && cyc < 3000) begin
            if (!held) begin
                in_valid = ($urandom_range(99) < vpct);
                in_data  = (dir_q.size() > 0) ? dir_q[0] : {$urandom, $urandom};
            end
            if (stall && m_full && !stalled) begin
                stall_cnt = 5;
                stalled = 1;
            end
            if (stall_cnt > 0) begin
                out_ready = 1'b0;
                stall_cnt--;
            end else begin
                out_ready = ($urandom_range(99) < rpct);
            end
            if (chaos) begin
                start    = ($urandom_range(3) == 0);
                cfg_func = 2'($urandom);
                cfg_rows = 8'($urandom);
            end
            tick();
            if (last_acc && dir_q.size() > 0) void'(dir_q.pop_front());
            held = in_valid && !last_acc;
            cyc++;
        end
        if (cyc >= 3000) chk("layer_timeout", 1, 0);
        start = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        model_reset();
        n_rst = 1'b0; start = 1'b0; cfg_func = 2'd0; cfg_rows = 8'd0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        @(negedge clk);
        tick();
        tick();
        n_rst = 1'b1;
        tick();

        // Single-row ReLU
        pops.delete();
        dir_q.push_back(64'h80_7F_01_FF_00_10_F0_05);
        do_layer(2'd0, 1, 100, 100, 0, 0);
        chk("relu_pops", pops.size(), 1);
        if (pops.size() == 1) chk("relu_row", pops[0], 64'h00_7F_01_00_00_10_00_05);

        // Streaming binary, continuous valid/ready
        pops.delete();
        dir_q.push_back(64'h01010101_01010101);
        dir_q.push_back(64'h80808080_80808080);
        dir_q.push_back(64'hFFFFFFFF_FFFFFFFF);
        dir_q.push_back(64'h7F7F7F7F_7F7F7F7F);
        do_layer(2'd1, 4, 100, 100, 0, 0);
        chk("bin_pops", pops.size(), 4);
        if (pops.size() == 4) begin
            chk("bin_r0", pops[0], 64'h01010101_01010101);
            chk("bin_r1", pops[1], 64'h0);
            chk("bin_r2", pops[2], 64'h0);
            chk("bin_r3", pops[3], 64'h01010101_01010101);
        end

        // Backpressure on identity, zero-row layer, config isolation
        pops.delete();
        do_layer(2'd2, 3, 100, 100, 1, 0);
        chk("bp_pops", pops.size(), 3);
        do_layer(2'd0, 0, 100, 100, 0, 0);
        do_layer(2'd0, 6, 80, 70, 0, 1);
        do_layer(2'd3, 255, 90, 90, 0, 0);

        // Reset mid-layer after two accepts
        start = 1'b1; cfg_func = 2'd3; cfg_rows = 8'd4; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 20 && m_left > 2; i++) begin
            in_valid = 1'b1; in_data = {$urandom, $urandom};
            tick();
        end
        chk("pre_reset_left", m_left, 2);
        n_rst = 1'b0;
        model_reset();
        tick();
        tick();
        n_rst = 1'b1;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        do_layer(2'd0, 4, 100, 100, 0, 0);

        for (int k = 0; k < 12; k++) begin
            do_layer(2'($urandom), $urandom_range(0, 9), $urandom_range(30, 100),
                     $urandom_range(30, 100), k[0], k[1]);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
